// File: rtl/barrido_display.sv
// barrido_display: time-multiplexed scanner for an 8-digit common-anode
// 7-segment display. A frame snapshot of datos/habilita_dig/punto is taken
// once per frame, then each digit is lit for PRESCALE cycles, separated by
// TIEMPO_MUERTO cycles with every anode off to prevent ghosting.
//
// Optional feature macro: BARRIDO_SUPRIME_CEROS_EN
//   When defined, leading zeros (digits k>=1 whose nibble is 0 and with no
//   enabled non-zero digit above them) stay dark. Timing is unchanged.
module barrido_display #(
    parameter int PRESCALE      = 100000,
    parameter int TIEMPO_MUERTO = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] datos,
    input  logic [7:0]  habilita_dig,
    input  logic [7:0]  punto,
    output logic [3:0]  Codigo_D,
    output logic [7:0]  anodo,
    output logic        punto_n,
    output logic        fin_barrido
);

    // Counter must hold max(PRESCALE, TIEMPO_MUERTO) - 1.
    localparam int CNT_MAX = (PRESCALE > TIEMPO_MUERTO) ? PRESCALE : TIEMPO_MUERTO;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] FIN_ON    = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] FIN_BLANK = CNT_W'(TIEMPO_MUERTO - 1);

    typedef enum logic {
        EST_ON    = 1'b0,
        EST_BLANK = 1'b1
    } estado_t;

    estado_t          estado_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [31:0]      datos_sh_q;
    logic [7:0]       hab_sh_q;
    logic [7:0]       punto_sh_q;
    logic [3:0]       codigo_q;
    logic [7:0]       anodo_q;
    logic             punto_n_q;
    logic             fin_q;

    logic [2:0]       idx_d;
    logic [7:0]       anodo_on_d;
    logic             apaga_punto_d;

`ifdef BARRIDO_SUPRIME_CEROS_EN
    // A digit is a leading zero when it is not digit 0, its nibble is 0, and
    // no higher digit is both enabled and non-zero.
    function automatic logic suprimir(input logic [31:0] d,
                                      input logic [7:0]  en,
                                      input logic [2:0]  k);
        logic s;
        s = (k != 3'd0) && (d[{k, 2'b00} +: 4] == 4'h0);
        for (int j = 0; j < 8; j++) begin
            if ((j > int'(k)) && en[j] && (d[4*j +: 4] != 4'h0)) begin
                s = 1'b0;
            end
        end
        return s;
    endfunction
`endif

    // Next digit index and the anode/decimal-point values used on ON entry.
    always_comb begin
        idx_d         = idx_q + 3'd1;
        anodo_on_d    = 8'hFF;
        apaga_punto_d = 1'b0;
`ifdef BARRIDO_SUPRIME_CEROS_EN
        if (hab_sh_q[idx_q] && !suprimir(datos_sh_q, hab_sh_q, idx_q)) begin
            anodo_on_d = ~(8'd1 << idx_q);
        end else begin
            anodo_on_d = 8'hFF;
        end
        apaga_punto_d = suprimir(datos_sh_q, hab_sh_q, idx_q);
`else
        if (hab_sh_q[idx_q]) begin
            anodo_on_d = ~(8'd1 << idx_q);
        end else begin
            anodo_on_d = 8'hFF;
        end
`endif
    end

    // Scan state machine: ON/BLANK sequencing, frame snapshot, registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= EST_ON;
            cnt_q      <= FIN_ON;
            idx_q      <= 3'd7;
            datos_sh_q <= 32'h0000_0000;
            hab_sh_q   <= 8'h00;
            punto_sh_q <= 8'h00;
            codigo_q   <= 4'h0;
            anodo_q    <= 8'hFF;
            punto_n_q  <= 1'b1;
            fin_q      <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            case (estado_q)
                EST_ON: begin
                    if (cnt_q == FIN_ON) begin
                        estado_q <= EST_BLANK;
                        cnt_q    <= '0;
                        idx_q    <= idx_d;
                        anodo_q  <= 8'hFF;
                        if (idx_d == 3'd0) begin
                            // Frame wrap: snapshot inputs, show digit 0 from the fresh sample.
                            datos_sh_q <= datos;
                            hab_sh_q   <= habilita_dig;
                            punto_sh_q <= punto;
                            codigo_q   <= datos[3:0];
                            punto_n_q  <= ~punto[0];
                            fin_q      <= 1'b1;
                        end else begin
                            codigo_q   <= datos_sh_q[{idx_d, 2'b00} +: 4];
                            punto_n_q  <= ~punto_sh_q[idx_d];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                EST_BLANK: begin
                    if (cnt_q == FIN_BLANK) begin
                        estado_q <= EST_ON;
                        cnt_q    <= '0;
                        anodo_q  <= anodo_on_d;
                        if (apaga_punto_d) begin
                            punto_n_q <= 1'b1;
                        end else begin
                            punto_n_q <= punto_n_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    estado_q <= EST_ON;
                    cnt_q    <= FIN_ON;
                    idx_q    <= 3'd7;
                    anodo_q  <= 8'hFF;
                end
            endcase
        end
    end

    assign Codigo_D    = codigo_q;
    assign anodo       = anodo_q;
    assign punto_n     = punto_n_q;
    assign fin_barrido = fin_q;

endmodule
